timer_ctrl: RTL and testbench
=============================

TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 32, as the width of the counter and compare registers.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-004 The block SHALL have port io_addr, input, 4 bits, the byte address of the register select; bits [1:0] are ignored.
REQ-005 The block SHALL have port io_we, input, 1 bit, the write strobe, sampled each cycle.
REQ-006 The block SHALL have port io_re, input, 1 bit, the read strobe.
REQ-007 The block SHALL have port io_wdata, input, 32 bits, the write data.
REQ-008 The block SHALL have port io_rdata, output, 32 bits, the read data, registered.
REQ-009 The block SHALL have port irq, output, 1 bit, the level interrupt.

Function
REQ-010 The register map SHALL be as follows:
- 0x0 CTRL, RW: bit0 EN, bit1 PERIODIC, bit2 IRQ_EN.
- 0x4 CMP, RW, CNT_W bits.
- 0x8 COUNT: reads the current count; any write clears it to 0.
- 0xC STATUS: bit0 MATCH, sticky, write-1-to-clear; bits[2:1] report the FSM state.
REQ-011 The FSM SHALL have three states:
- IDLE: counter held.
- RUN: counter increments by 1 every cycle.
- DONE: counter held at the match value.
REQ-012 IDLE SHALL go to RUN on the cycle after a CTRL write with EN=1.
REQ-013 RUN or DONE SHALL go to IDLE on the cycle after a CTRL write with EN=0.
REQ-014 A match SHALL be detected when the state is RUN and count == CMP.
REQ-015 On a match in RUN, STATUS.MATCH SHALL be set on the next edge.
REQ-016 On a match with PERIODIC=1, count SHALL be 0 next cycle and the state SHALL stay RUN; the period is CMP+1 cycles.
REQ-017 On a match with PERIODIC=0, the count SHALL be held and the state SHALL go to DONE; a CTRL write with EN=1 from DONE clears count and re-enters RUN.
REQ-018 CMP=0 SHALL produce a match on every RUN cycle in periodic mode, and an immediate DONE in one-shot mode.
REQ-019 Count SHALL wrap modulo 2^CNT_W without setting MATCH when CMP is changed below the current count.
REQ-020 A COUNT write in the same cycle as a match SHALL leave count = 0; MATCH SHALL still set, and for one-shot the state SHALL still go to DONE.
REQ-021 A STATUS W1C in the same cycle as a new match SHALL leave MATCH = 1 (set wins).
REQ-022 irq SHALL equal STATUS.MATCH AND CTRL.IRQ_EN, driven combinationally from registers.
REQ-023 io_rdata SHALL present the selected register one cycle after io_re=1 and hold its last value otherwise.
REQ-024 Writes SHALL take effect on the edge where io_we=1; a CMP write is used for matching from the next cycle.

Reset
REQ-025 On rst=1 the block SHALL set CTRL=0, CMP=0, count=0, MATCH=0, state=IDLE, io_rdata=0 and irq=0 on the next edge.
REQ-026 A reset asserted mid-RUN SHALL abandon the count with no MATCH set; rst SHALL override any simultaneous io_we.

Structure
REQ-027 A shared package SHALL hold:
- the register offset constants CTRL/CMP/COUNT/STATUS;
- the CTRL bit indices;
- the FSM state encoding IDLE=2'b00, RUN=2'b01, DONE=2'b10.
REQ-028 The count register SHALL be the codebase PipeReg primitive with CNT_W width; its D input and enable SHALL come from the controller next-state logic.
REQ-029 No further sub-module is needed; the register file and FSM SHALL reside in timer_ctrl.

Verification
REQ-030 Periodic mode: CMP=3, CTRL=0b011 -> count sequence 0,1,2,3,0,1…; MATCH set 1 cycle after each count=3; period 4.
REQ-031 One-shot mode: CMP=5, CTRL=0b001 -> count stops at 5, STATUS state=DONE, MATCH=1; a CTRL=0b001 rewrite -> restart from 0.
REQ-032 Interrupt: IRQ_EN=1, match -> irq=1; W1C STATUS=1 -> irq=0 next cycle; W1C coincident with a match -> irq stays 1.
REQ-033 Collision: COUNT write on the match cycle -> count=0 and MATCH=1; CMP=0 in periodic mode -> MATCH every RUN cycle.
REQ-034 Reset: rst during RUN at count=100 -> all registers 0, state IDLE, irq=0; io_we asserted together with rst is ignored.
REQ-035 Readback: write CMP=0xDEADBEEF, then io_re at 0x4 -> io_rdata=0xDEADBEEF exactly one cycle later.

Source files
------------

// File: rtl/timer_ctrl_pkg.sv
// Shared definitions for the timer controller.
// Holds the register byte offsets, the CTRL bit positions, the FSM state
// encoding and a helper that maps a byte address onto a register word index.
package timer_ctrl_pkg;

  // Register byte offsets. Only bits [3:2] select a register.
  localparam logic [3:0] OFS_CTRL   = 4'h0;
  localparam logic [3:0] OFS_CMP    = 4'h4;
  localparam logic [3:0] OFS_COUNT  = 4'h8;
  localparam logic [3:0] OFS_STATUS = 4'hC;

  // CTRL bit indices
  localparam int unsigned CTRL_EN       = 0;
  localparam int unsigned CTRL_PERIODIC = 1;
  localparam int unsigned CTRL_IRQ_EN   = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Word index of a register offset constant.
  function automatic logic [1:0] word_idx(input logic [3:0] ofs);
    return ofs[3:2];
  endfunction

endpackage

// File: rtl/timer_ctrl_pipe_reg.sv
// pipe_reg: plain enabled data register.
// Ports:
//   clk - clock
//   en  - load enable; q takes d on the rising edge when high
//   d   - next value
//   q   - registered value
// It has no reset of its own: the owner clears it by driving en=1, d=0.
module pipe_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (en) q <= d;
  end

endmodule

// File: rtl/timer_ctrl.sv
// timer_ctrl: memory-mapped compare timer with one-shot and periodic modes.
// Ports:
//   clk      - clock, all state updates on the rising edge
//   rst      - synchronous active-high reset
//   io_addr  - register byte address, bits [1:0] ignored
//   io_we    - write strobe
//   io_re    - read strobe
//   io_wdata - write data
//   io_rdata - registered read data, updated one cycle after io_re
//   irq      - level interrupt, STATUS.MATCH and CTRL.IRQ_EN
// Registers: 0x0 CTRL {IRQ_EN,PERIODIC,EN}, 0x4 CMP, 0x8 COUNT (write clears),
// 0xC STATUS {state[1:0], MATCH(W1C)}.
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  io_addr,
  input  logic        io_we,
  input  logic        io_re,
  input  logic [31:0] io_wdata,
  output logic [31:0] io_rdata,
  output logic        irq
);

  state_t             state;
  state_t             state_nxt;
  logic               ctrl_en;
  logic               ctrl_periodic;
  logic               ctrl_irq_en;
  logic [CNT_W-1:0]   cmp;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   cnt_d;
  logic               cnt_en;
  logic               match_flag;
  logic               match_hit;
  logic [1:0]         sel;
  logic [1:0]         addr_unused;
  logic               wr_ctrl;
  logic               wr_cmp;
  logic               wr_count;
  logic               wr_status;
  logic [31:0]        rd_mux;

  // Byte-lane bits are not part of the register select.
  assign addr_unused = io_addr[1:0];
  assign sel         = io_addr[3:2];

  assign wr_ctrl   = io_we && (sel == word_idx(OFS_CTRL));
  assign wr_cmp    = io_we && (sel == word_idx(OFS_CMP));
  assign wr_count  = io_we && (sel == word_idx(OFS_COUNT));
  assign wr_status = io_we && (sel == word_idx(OFS_STATUS));

  assign match_hit = (state == ST_RUN) && (count == cmp);

  // Next-state and counter control
  always_comb begin
    state_nxt = state;
    cnt_en    = 1'b0;
    cnt_d     = count;
    unique case (state)
      ST_IDLE: begin
        if (wr_ctrl && io_wdata[CTRL_EN]) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        cnt_en = 1'b1;
        if (match_hit) begin
          if (ctrl_periodic) begin
            cnt_d = '0;
          end else begin
            cnt_d     = count;
            state_nxt = ST_DONE;
          end
        end else begin
          cnt_d = count + CNT_W'(1);
        end
        if (wr_ctrl && !io_wdata[CTRL_EN]) state_nxt = ST_IDLE;
      end
      ST_DONE: begin
        if (wr_ctrl) begin
          if (io_wdata[CTRL_EN]) begin
            state_nxt = ST_RUN;
            cnt_en    = 1'b1;
            cnt_d     = '0;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    // A COUNT write wins over counting and matching; reset wins over all.
    if (wr_count || rst) begin
      cnt_en = 1'b1;
      cnt_d  = '0;
    end
  end

  pipe_reg #(
    .DATA_W(CNT_W)
  ) u_count (
    .clk(clk),
    .en (cnt_en),
    .d  (cnt_d),
    .q  (count)
  );

  // Read mux
  always_comb begin
    rd_mux = 32'h0;
    unique case (sel)
      2'd0:    rd_mux = {29'h0, ctrl_irq_en, ctrl_periodic, ctrl_en};
      2'd1:    rd_mux = 32'(cmp);
      2'd2:    rd_mux = 32'(count);
      default: rd_mux = {29'h0, state, match_flag};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      ctrl_en       <= 1'b0;
      ctrl_periodic <= 1'b0;
      ctrl_irq_en   <= 1'b0;
      cmp           <= '0;
      match_flag    <= 1'b0;
      io_rdata      <= 32'h0;
    end else begin
      state <= state_nxt;
      if (wr_ctrl) begin
        ctrl_en       <= io_wdata[CTRL_EN];
        ctrl_periodic <= io_wdata[CTRL_PERIODIC];
        ctrl_irq_en   <= io_wdata[CTRL_IRQ_EN];
      end
      if (wr_cmp) cmp <= io_wdata[CNT_W-1:0];
      // A new match beats a simultaneous write-1-to-clear.
      if (match_hit) begin
        match_flag <= 1'b1;
      end else if (wr_status && io_wdata[0]) begin
        match_flag <= 1'b0;
      end
      if (io_re) io_rdata <= rd_mux;
    end
  end

  assign irq = match_flag && ctrl_irq_en;

endmodule

// File: tb/tb_timer_ctrl.sv
module tb_timer_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  io_addr;
  logic        io_we;
  logic        io_re;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];
  logic        re_d;

  localparam logic [3:0] A_CTRL   = 4'h0;
  localparam logic [3:0] A_CMP    = 4'h4;
  localparam logic [3:0] A_COUNT  = 4'h8;
  localparam logic [3:0] A_STATUS = 4'hC;

  always #5 clk = ~clk;

  timer_ctrl #(.CNT_W(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .io_addr (io_addr),
    .io_we   (io_we),
    .io_re   (io_re),
    .io_wdata(io_wdata),
    .io_rdata(io_rdata),
    .irq     (irq)
  );

  // Read-return tracker: io_rdata is valid the cycle after io_re.
  always @(posedge clk) re_d <= io_re;

  // Monitor: pops the scoreboard on each read return.
  always @(negedge clk) begin
    if (re_d === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_read: got 0x%08h, no expected value queued", io_rdata);
      end else begin
        logic [31:0] e;
        string       nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (io_rdata !== e) begin
          failures++;
          $display("FAIL %s: got 0x%08h expected 0x%08h", nm, io_rdata, e);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    io_we = 1'b1; io_addr = a; io_wdata = d;
    cyc(1);
    io_we = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] e, input string nm);
    io_re = 1'b1; io_addr = a;
    exp_q.push_back(e);
    name_q.push_back(nm);
    cyc(1);
    io_re = 1'b0;
  endtask

  task automatic chk_irq(input logic e, input string nm);
    checks++;
    if (irq !== e) begin
      failures++;
      $display("FAIL %s: irq got %b expected %b", nm, irq, e);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; io_addr = 4'h0; io_we = 1'b0; io_re = 1'b0; io_wdata = 32'h0;
    cyc(3);
    rst = 1'b0;

    // Reset state
    rd(A_CTRL,   32'h0, "rst_ctrl");
    rd(A_CMP,    32'h0, "rst_cmp");
    rd(A_COUNT,  32'h0, "rst_count");
    rd(A_STATUS, 32'h0, "rst_status");
    chk_irq(1'b0, "rst_irq");

    // Readback
    wr(A_CMP, 32'hDEADBEEF);
    rd(A_CMP, 32'hDEADBEEF, "cmp_readback");

    // Periodic, CMP=3: count sequence
    do_reset();
    wr(A_CMP, 32'd3);
    wr(A_CTRL, 32'h3);
    rd(A_COUNT, 32'd0, "per_cnt0");
    rd(A_COUNT, 32'd1, "per_cnt1");
    rd(A_COUNT, 32'd2, "per_cnt2");
    rd(A_COUNT, 32'd3, "per_cnt3");
    rd(A_COUNT, 32'd0, "per_cnt4");
    rd(A_COUNT, 32'd1, "per_cnt5");

    // Periodic, CMP=3: MATCH timing and period 4
    do_reset();
    wr(A_CMP, 32'd3);
    wr(A_CTRL, 32'h3);
    rd(A_STATUS, 32'h2, "per_st1");
    rd(A_STATUS, 32'h2, "per_st2");
    rd(A_STATUS, 32'h2, "per_st3");
    rd(A_STATUS, 32'h2, "per_st4");
    rd(A_STATUS, 32'h3, "per_st5_match");
    wr(A_STATUS, 32'h1);
    rd(A_STATUS, 32'h2, "per_st_cleared");
    rd(A_STATUS, 32'h2, "per_st_before2");
    rd(A_STATUS, 32'h3, "per_st_match2");

    // One-shot, CMP=5, restart, then disable
    do_reset();
    wr(A_CMP, 32'd5);
    wr(A_CTRL, 32'h1);
    cyc(8);
    rd(A_COUNT, 32'd5, "os_cnt_hold");
    rd(A_STATUS, 32'h5, "os_done");
    wr(A_CTRL, 32'h1);
    rd(A_COUNT, 32'd0, "os_restart0");
    rd(A_COUNT, 32'd1, "os_restart1");
    rd(A_STATUS, 32'h3, "os_run_again");
    wr(A_CTRL, 32'h0);
    rd(A_COUNT, 32'd4, "dis_cnt_a");
    rd(A_COUNT, 32'd4, "dis_cnt_b");
    rd(A_STATUS, 32'h1, "dis_idle");

    // One-shot, CMP=0: immediate DONE
    do_reset();
    wr(A_CTRL, 32'h1);
    rd(A_STATUS, 32'h2, "os0_run");
    rd(A_STATUS, 32'h5, "os0_done");

    // Periodic, CMP=0: match every cycle, W1C loses to new match
    do_reset();
    wr(A_CTRL, 32'h3);
    rd(A_STATUS, 32'h2, "per0_first");
    rd(A_STATUS, 32'h3, "per0_match");
    wr(A_STATUS, 32'h1);
    rd(A_STATUS, 32'h3, "per0_w1c_lose");
    rd(A_COUNT, 32'd0, "per0_cnt");

    // COUNT write on the one-shot match cycle
    do_reset();
    wr(A_CMP, 32'd3);
    wr(A_CTRL, 32'h1);
    cyc(3);
    wr(A_COUNT, 32'h0);
    rd(A_COUNT, 32'd0, "coll_cnt");
    rd(A_STATUS, 32'h5, "coll_status");

    // CMP moved below count: no match
    do_reset();
    wr(A_CMP, 32'd10);
    wr(A_CTRL, 32'h3);
    cyc(4);
    wr(A_CMP, 32'd2);
    rd(A_COUNT, 32'd5, "wrap_cnt");
    rd(A_STATUS, 32'h2, "wrap_nomatch");

    // Interrupt
    do_reset();
    wr(A_CMP, 32'd3);
    wr(A_CTRL, 32'h7);
    cyc(3);
    chk_irq(1'b0, "irq_before");
    cyc(1);
    chk_irq(1'b1, "irq_set");
    wr(A_STATUS, 32'h1);
    chk_irq(1'b0, "irq_w1c");
    cyc(2);
    wr(A_STATUS, 32'h1);
    chk_irq(1'b1, "irq_w1c_coincident");
    rd(A_CTRL, 32'h7, "ctrl_readback");

    // Reset mid-RUN at count=100 with simultaneous write
    do_reset();
    wr(A_CMP, 32'd200);
    wr(A_CTRL, 32'h7);
    cyc(100);
    rd(A_COUNT, 32'd100, "run_cnt100");
    rst = 1'b1; io_we = 1'b1; io_addr = A_CTRL; io_wdata = 32'h7;
    cyc(1);
    rst = 1'b0; io_we = 1'b0;
    checks++;
    if (io_rdata !== 32'h0) begin
      failures++;
      $display("FAIL rst_rdata: got 0x%08h expected 0x00000000", io_rdata);
    end
    chk_irq(1'b0, "rst_run_irq");
    rd(A_CTRL,   32'h0, "rst_run_ctrl");
    rd(A_CMP,    32'h0, "rst_run_cmp");
    rd(A_COUNT,  32'h0, "rst_run_count");
    rd(A_STATUS, 32'h0, "rst_run_status");

    cyc(3);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
